// File: rtl/axi3_rd_arbiter.sv
// axi3_rd_arbiter: round-robin AR arbitration of N_REQ AXI3 read requesters onto one bus port,
// with R beats routed back combinationally by RID; one outstanding burst per requester.
module axi3_rd_arbiter #(
    parameter int N_REQ      = 3,
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ*ADDR_WIDTH-1:0] s_araddr,
    input  logic [N_REQ*4-1:0]          s_arlen,
    input  logic [N_REQ*3-1:0]          s_arsize,
    input  logic [N_REQ*2-1:0]          s_arburst,
    input  logic [N_REQ-1:0]            s_arvalid,
    output logic [N_REQ-1:0]            s_arready,
    output logic [DATA_WIDTH-1:0]       s_rdata,
    output logic [1:0]                  s_rresp,
    output logic                        s_rlast,
    output logic [N_REQ-1:0]            s_rvalid,
    input  logic [N_REQ-1:0]            s_rready,
    output logic [ID_WIDTH-1:0]         m_arid,
    output logic [ADDR_WIDTH-1:0]       m_araddr,
    output logic [3:0]                  m_arlen,
    output logic [2:0]                  m_arsize,
    output logic [1:0]                  m_arburst,
    output logic                        m_arvalid,
    input  logic                        m_arready,
    input  logic [ID_WIDTH-1:0]         m_rid,
    input  logic [DATA_WIDTH-1:0]       m_rdata,
    input  logic [1:0]                  m_rresp,
    input  logic                        m_rlast,
    input  logic                        m_rvalid,
    output logic                        m_rready,
    output logic                        err_bad_rid
);
    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;
    arb_state_t       r_state, w_state_nxt;
    logic [GW-1:0]    r_grant, w_grant_nxt, r_rr_ptr, w_rr_ptr_nxt, w_idx;
    logic [N_REQ-1:0] r_outstanding, w_elig, w_gnt_oh, w_ar_set, w_r_clr, w_rid_hit;
    logic             w_lock, w_ar_hs, w_rid_own, r_err;

    assign w_lock   = (r_state == ARB_LOCK);
    assign w_elig   = s_arvalid & ~r_outstanding;
    assign w_gnt_oh = N_REQ'(1) << r_grant;
    assign w_ar_hs  = m_arvalid & m_arready;
    assign w_ar_set = w_ar_hs ? w_gnt_oh : '0;

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        w_idx        = '0;
        if (!w_lock) begin
            // scanned from the far end so the surviving hit is the nearest one at or after rr_ptr
            for (int k = N_REQ - 1; k >= 0; k--) begin
                w_idx = GW'((int'(r_rr_ptr) + k) % N_REQ);
                if (w_elig[w_idx]) begin
                    w_grant_nxt = w_idx;
                    w_state_nxt = ARB_LOCK;
                end
            end
        end else if (w_ar_hs) begin
            w_rr_ptr_nxt = (int'(r_grant) == N_REQ - 1) ? '0 : r_grant + 1'b1;
            w_state_nxt  = ARB_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ARB_IDLE;
            r_grant       <= '0;
            r_rr_ptr      <= '0;
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_rr_ptr      <= w_rr_ptr_nxt;
            r_outstanding <= (r_outstanding | w_ar_set) & ~w_r_clr;
            r_err         <= r_err | (m_rvalid & ~w_rid_own);
        end
    end

    assign m_arid    = ID_WIDTH'(r_grant);
    assign m_araddr  = s_araddr[int'(r_grant)*ADDR_WIDTH +: ADDR_WIDTH];
    assign m_arlen   = s_arlen[int'(r_grant)*4 +: 4];
    assign m_arsize  = s_arsize[int'(r_grant)*3 +: 3];
    assign m_arburst = s_arburst[int'(r_grant)*2 +: 2];
    assign m_arvalid = w_lock & s_arvalid[r_grant];
    assign s_arready = (w_lock & m_arready) ? w_gnt_oh : '0;

    genvar i;
    generate
        for (i = 0; i < N_REQ; i++) begin : g_rid
            assign w_rid_hit[i] = r_outstanding[i] & (m_rid == ID_WIDTH'(i));
        end
    endgenerate

    // unowned beats are swallowed so a stray RID can never stall the bus
    assign w_rid_own   = |w_rid_hit;
    assign m_rready    = w_rid_own ? |(w_rid_hit & s_rready) : m_rvalid;
    assign s_rvalid    = m_rvalid ? w_rid_hit : '0;
    assign w_r_clr     = (m_rvalid & m_rready & m_rlast) ? w_rid_hit : '0;
    assign s_rdata     = m_rdata;
    assign s_rresp     = m_rresp;
    assign s_rlast     = m_rlast;
    assign err_bad_rid = r_err;
endmodule

// File: tb/tb_axi3_rd_arbiter.sv
// tb_axi3_rd_arbiter: directed scenarios plus a randomized run against a transaction-level model
// of round-robin grants, per-requester outstanding bursts and RID routing.
module tb_axi3_rd_arbiter;
    localparam int N = 3, IW = 4, AW = 32, DW = 32;
    logic clk = 1'b0, rst = 1'b0;
    logic [N*AW-1:0] s_araddr;
    logic [N*4-1:0]  s_arlen;
    logic [N*3-1:0]  s_arsize;
    logic [N*2-1:0]  s_arburst;
    logic [N-1:0]    s_arvalid, s_arready, s_rvalid, s_rready;
    logic [DW-1:0]   s_rdata, m_rdata;
    logic [1:0]      s_rresp, m_rresp, m_arburst;
    logic            s_rlast, m_rlast, m_rvalid, m_rready, m_arvalid, m_arready, err_bad_rid;
    logic [IW-1:0]   m_arid, m_rid;
    logic [AW-1:0]   m_araddr;
    logic [3:0]      m_arlen;
    logic [2:0]      m_arsize;
    int checks = 0, errors = 0;

    axi3_rd_arbiter #(.N_REQ(N), .ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_rid(m_rid),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready), .err_bad_rid(err_bad_rid)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] beat_data(int id, int b);
        return {8'(id), 8'(b), 16'h5AC3};
    endfunction

    task automatic set_req(int i, logic [AW-1:0] a, logic [3:0] l);
        s_araddr[i*AW +: AW] = a;
        s_arlen[i*4 +: 4] = l;
    endtask

    task automatic do_reset;
        rst = 1'b1; s_arvalid = '0; s_rready = '0; m_arready = 1'b0;
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0;
        s_arlen = '0; s_arsize = {N{3'd2}}; s_arburst = {N{2'd1}};
        for (int i = 0; i < N; i++) s_araddr[i*AW +: AW] = $urandom;
        step; step;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        rst = 1'b1; #1;
        checks++; if (s_arready !== 3'b000) begin errors++; $display("FAIL rst_s_arready got %b exp 000", s_arready); end
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL rst_m_arvalid got %b exp 0", m_arvalid); end
        checks++; if (s_rvalid !== 3'b000) begin errors++; $display("FAIL rst_s_rvalid got %b exp 000", s_rvalid); end
        checks++; if (m_rready !== 1'b0) begin errors++; $display("FAIL rst_m_rready got %b exp 0", m_rready); end
        checks++; if (err_bad_rid !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err_bad_rid); end
        rst = 1'b0; s_arvalid = 3'b010; m_arready = 1'b1;
        step; #1;
        checks++; if ({m_arvalid, m_arid} !== {1'b1, 4'd1}) begin errors++; $display("FAIL rst_first_ar got %b/%0d exp 1/1", m_arvalid, m_arid); end
        step; s_arvalid = 3'b100; m_arready = 1'b0;
        step; #1;
        checks++; if ({m_arvalid, m_arid} !== {1'b1, 4'd2}) begin errors++; $display("FAIL rst_lock2 got %b/%0d exp 1/2", m_arvalid, m_arid); end
        m_arready = 1'b1; #2; rst = 1'b1; #1;
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL rst_async_arvalid got %b exp 0", m_arvalid); end
        checks++; if (s_arready !== 3'b000) begin errors++; $display("FAIL rst_async_arready got %b exp 000", s_arready); end
        step; rst = 1'b0; s_arvalid = 3'b111; m_arready = 1'b0;
        step; #1;
        checks++; if ({m_arvalid, m_arid} !== {1'b1, 4'd0}) begin errors++; $display("FAIL rst_after_grant got %b/%0d exp 1/0", m_arvalid, m_arid); end
        m_arready = 1'b1;
        step; s_arvalid = 3'b110; m_arready = 1'b0;
        step; #1;
        checks++; if ({m_arvalid, m_arid} !== {1'b1, 4'd1}) begin errors++; $display("FAIL rst_outstanding_cleared got %b/%0d exp 1/1", m_arvalid, m_arid); end
    endtask

    task automatic test_round_robin;
        int seq[4] = '{0, 1, 2, 0};
        int last = 0;
        do_reset;
        s_arvalid = 3'b111; m_arready = 1'b1; s_rready = '1;
        for (int t = 1; t <= 7; t++) begin
            step;
            m_rvalid = (t % 2 == 0); m_rid = IW'(last); m_rlast = 1'b1; m_rdata = DW'(t);
            #1;
            if (t % 2 == 1) begin
                checks++; if ({m_arvalid, m_arid} !== {1'b1, IW'(seq[t/2])}) begin errors++; $display("FAIL rr_ar t=%0d got %b/%0d exp 1/%0d", t, m_arvalid, m_arid, seq[t/2]); end
                last = seq[t/2];
            end else begin
                checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL rr_gap t=%0d got %b exp 0", t, m_arvalid); end
                checks++; if (s_rvalid !== (N'(1) << last) || m_rready !== 1'b1) begin errors++; $display("FAIL rr_ret t=%0d got %b/%b exp %b/1", t, s_rvalid, m_rready, N'(1) << last); end
            end
        end
        step; m_rvalid = 1'b0; s_arvalid = '0;
    endtask

    task automatic test_outstanding_block;
        int beats = 0, cyc = 0;
        do_reset;
        set_req(1, $urandom, 4'd7); s_arvalid = 3'b010; m_arready = 1'b1;
        step; #1;
        checks++; if ({m_arvalid, m_arid, m_arlen} !== {1'b1, 4'd1, 4'd7}) begin errors++; $display("FAIL ob_ar got %b/%0d/%0d exp 1/1/7", m_arvalid, m_arid, m_arlen); end
        step;
        while (beats < 8 && cyc < 60) begin
            m_rvalid = 1'b1; m_rid = 4'd1; m_rdata = beat_data(1, beats); m_rlast = (beats == 7);
            s_rready[1] = 1'($urandom_range(0, 1));
            #1;
            checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL ob_no_reissue beat=%0d got %b exp 0", beats, m_arvalid); end
            checks++; if (m_rready !== s_rready[1] || s_rvalid !== 3'b010) begin errors++; $display("FAIL ob_route got %b/%b exp %b/010", m_rready, s_rvalid, s_rready[1]); end
            if (s_rready[1]) beats++;
            cyc++;
            step;
        end
        checks++; if (beats != 8) begin errors++; $display("FAIL ob_timeout beats got %0d exp 8", beats); end
        m_rvalid = 1'b0; m_rlast = 1'b0; #1;
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL ob_after_last got %b exp 0", m_arvalid); end
        step; #1;
        checks++; if ({m_arvalid, m_arid} !== {1'b1, 4'd1}) begin errors++; $display("FAIL ob_reissue got %b/%0d exp 1/1", m_arvalid, m_arid); end
    endtask

    task automatic test_r_routing;
        int sent[N], rcv[N];
        int cur = -1, stall2 = 3, k = 0;
        do_reset;
        set_req(0, $urandom, 4'd3); set_req(2, $urandom, 4'd3); s_arvalid = 3'b101; m_arready = 1'b1;
        step; #1;
        checks++; if ({m_arvalid, m_arid} !== {1'b1, 4'd0}) begin errors++; $display("FAIL rt_ar0 got %b/%0d exp 1/0", m_arvalid, m_arid); end
        step; s_arvalid = 3'b100;
        step; #1;
        checks++; if ({m_arvalid, m_arid} !== {1'b1, 4'd2}) begin errors++; $display("FAIL rt_ar2 got %b/%0d exp 1/2", m_arvalid, m_arid); end
        step; s_arvalid = '0; m_arready = 1'b0;
        for (int i = 0; i < N; i++) begin sent[i] = 0; rcv[i] = 0; end
        while ((sent[0] < 4 || sent[2] < 4) && k < 80) begin
            if (cur < 0) cur = (sent[2] < 4 && ($urandom_range(0, 1) == 1 || sent[0] >= 4)) ? 2 : 0;
            m_rvalid = 1'b1; m_rid = IW'(cur); m_rdata = beat_data(cur, sent[cur]); m_rlast = (sent[cur] == 3);
            s_rready = {1'b1, 1'($urandom), 1'b1};
            if (cur == 2 && stall2 > 0) begin s_rready[2] = 1'b0; stall2--; end
            #1;
            checks++; if (s_rvalid !== (N'(1) << cur)) begin errors++; $display("FAIL rt_svalid rid=%0d got %b exp %b", cur, s_rvalid, N'(1) << cur); end
            checks++; if (m_rready !== s_rready[cur]) begin errors++; $display("FAIL rt_mready rid=%0d got %b exp %b", cur, m_rready, s_rready[cur]); end
            for (int i = 0; i < N; i++)
                if (s_rvalid[i] && s_rready[i]) begin
                    checks++; if (s_rdata !== beat_data(i, rcv[i])) begin errors++; $display("FAIL rt_data req=%0d got %h exp %h", i, s_rdata, beat_data(i, rcv[i])); end
                    rcv[i]++;
                end
            if (m_rready) begin sent[cur]++; cur = -1; end
            k++;
            step;
        end
        m_rvalid = 1'b0;
        checks++; if (rcv[0] != 4 || rcv[2] != 4 || rcv[1] != 0) begin errors++; $display("FAIL rt_counts got %0d/%0d/%0d exp 4/0/4", rcv[0], rcv[1], rcv[2]); end
    endtask

    task automatic test_ar_hold;
        logic [AW-1:0] a0, a2;
        a0 = $urandom; a2 = $urandom;
        do_reset;
        set_req(1, $urandom, 4'd0); s_arvalid = 3'b010; m_arready = 1'b1; s_rready = '1;
        step; #1;
        checks++; if ({m_arvalid, m_arid} !== {1'b1, 4'd1}) begin errors++; $display("FAIL hold_pre got %b/%0d exp 1/1", m_arvalid, m_arid); end
        step; s_arvalid = '0; m_rvalid = 1'b1; m_rid = 4'd1; m_rlast = 1'b1;
        step; m_rvalid = 1'b0; set_req(0, a0, 4'd2); set_req(2, a2, 4'd5); s_arvalid = 3'b101; m_arready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step; #1;
            checks++; if ({m_arvalid, m_arid, m_araddr} !== {1'b1, 4'd2, a2}) begin errors++; $display("FAIL hold_stable k=%0d got %b/%0d/%h exp 1/2/%h", k, m_arvalid, m_arid, m_araddr, a2); end
            checks++; if (s_arready !== 3'b000) begin errors++; $display("FAIL hold_arready k=%0d got %b exp 000", k, s_arready); end
        end
        m_arready = 1'b1; #1;
        checks++; if (s_arready !== 3'b100) begin errors++; $display("FAIL hold_hs got %b exp 100", s_arready); end
        step; s_arvalid = 3'b001; #1;
        checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL hold_gap got %b exp 0", m_arvalid); end
        step; #1;
        checks++; if ({m_arvalid, m_arid, m_araddr} !== {1'b1, 4'd0, a0}) begin errors++; $display("FAIL hold_next got %b/%0d/%h exp 1/0/%h", m_arvalid, m_arid, m_araddr, a0); end
    endtask

    task automatic test_bad_rid;
        do_reset;
        m_rvalid = 1'b1; m_rid = 4'd5; m_rdata = $urandom; m_rlast = 1'b1; #1;
        checks++; if (m_rready !== 1'b1 || s_rvalid !== 3'b000) begin errors++; $display("FAIL bad_route got %b/%b exp 1/000", m_rready, s_rvalid); end
        checks++; if (err_bad_rid !== 1'b0) begin errors++; $display("FAIL bad_err_early got %b exp 0", err_bad_rid); end
        step; m_rvalid = 1'b0; #1;
        checks++; if (err_bad_rid !== 1'b1) begin errors++; $display("FAIL bad_err_set got %b exp 1", err_bad_rid); end
        repeat (3) step;
        #1;
        checks++; if (err_bad_rid !== 1'b1) begin errors++; $display("FAIL bad_err_sticky got %b exp 1", err_bad_rid); end
        rst = 1'b1; #1;
        checks++; if (err_bad_rid !== 1'b0) begin errors++; $display("FAIL bad_err_reset got %b exp 0", err_bad_rid); end
        step; rst = 1'b0;
    endtask

    task automatic test_random;
        int exp_g, nxt_g, ptr, cur, hs, c;
        bit out_m[N];
        int left[N], bt[N];
        logic [AW-1:0] addr[N];
        logic [3:0] len[N];
        logic [N-1:0] elig;
        do_reset;
        exp_g = -1; ptr = 0; cur = -1; hs = -1;
        for (int i = 0; i < N; i++) begin out_m[i] = 0; left[i] = 0; bt[i] = 0; addr[i] = '0; len[i] = '0; end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int i = 0; i < N; i++)
                if (!s_arvalid[i] && $urandom_range(0, 3) == 0) begin
                    addr[i] = $urandom; len[i] = 4'($urandom_range(0, 7));
                    set_req(i, addr[i], len[i]); s_arvalid[i] = 1'b1;
                end
            m_arready = ($urandom_range(0, 2) != 0);
            if (cur < 0 && $urandom_range(0, 1) == 1) begin
                c = $urandom_range(0, N - 1);
                for (int k = 0; k < N; k++) if (cur < 0 && left[(c + k) % N] > 0) cur = (c + k) % N;
            end
            m_rvalid = (cur >= 0);
            if (cur >= 0) begin m_rid = IW'(cur); m_rdata = beat_data(cur, bt[cur]); m_rlast = (left[cur] == 1); end
            s_rready = N'($urandom);
            #1;
            if (exp_g >= 0) begin
                checks++; if ({m_arvalid, m_arid} !== {1'b1, IW'(exp_g)}) begin errors++; $display("FAIL rnd_ar cyc=%0d got %b/%0d exp 1/%0d", cyc, m_arvalid, m_arid, exp_g); end
                checks++; if (m_araddr !== addr[exp_g] || m_arlen !== len[exp_g]) begin errors++; $display("FAIL rnd_payload cyc=%0d got %h/%0d exp %h/%0d", cyc, m_araddr, m_arlen, addr[exp_g], len[exp_g]); end
                checks++; if (s_arready !== (m_arready ? (N'(1) << exp_g) : N'(0))) begin errors++; $display("FAIL rnd_arready cyc=%0d got %b", cyc, s_arready); end
            end else begin
                checks++; if (m_arvalid !== 1'b0) begin errors++; $display("FAIL rnd_idle cyc=%0d got %b exp 0", cyc, m_arvalid); end
            end
            if (cur >= 0) begin
                checks++; if (s_rvalid !== (N'(1) << cur) || m_rready !== s_rready[cur]) begin errors++; $display("FAIL rnd_r cyc=%0d rid=%0d got %b/%b exp %b/%b", cyc, cur, s_rvalid, m_rready, N'(1) << cur, s_rready[cur]); end
                checks++; if (s_rdata !== beat_data(cur, bt[cur])) begin errors++; $display("FAIL rnd_rdata cyc=%0d got %h exp %h", cyc, s_rdata, beat_data(cur, bt[cur])); end
            end else begin
                checks++; if (s_rvalid !== '0) begin errors++; $display("FAIL rnd_rquiet cyc=%0d got %b exp 0", cyc, s_rvalid); end
            end
            elig = s_arvalid;
            for (int i = 0; i < N; i++) if (out_m[i]) elig[i] = 1'b0;
            nxt_g = exp_g;
            if (exp_g < 0) begin
                for (int k = 0; k < N; k++) if (nxt_g < 0 && elig[(ptr + k) % N]) nxt_g = (ptr + k) % N;
            end else if (m_arready) begin
                out_m[exp_g] = 1; left[exp_g] = len[exp_g] + 1; bt[exp_g] = 0;
                ptr = (exp_g + 1) % N; hs = exp_g; nxt_g = -1;
            end
            if (cur >= 0 && s_rready[cur]) begin
                bt[cur]++; left[cur]--;
                if (left[cur] == 0) out_m[cur] = 0;
                cur = -1;
            end
            exp_g = nxt_g;
            step;
            if (hs >= 0) s_arvalid[hs] = 1'b0;
            hs = -1;
        end
        m_rvalid = 1'b0; s_arvalid = '0;
    endtask

    initial begin
        test_reset;
        test_round_robin;
        test_outstanding_block;
        test_r_routing;
        test_ar_hold;
        test_bad_rid;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
